// File: rtl/reg_file_pkg.sv
// Shared types and default sizes for the spilling register file.
package reg_file_pkg;

    localparam int DEF_DW = 8;
    localparam int DEF_PW = 3;

    typedef enum logic [1:0] {
        IDLE,
        SPILL,
        FILL
    } xfer_state_t;

endpackage

// File: rtl/reg_file_xfer_fsm.sv
// Spill/fill sequencer: walks idx over every register, one beat per mem_ack.
import reg_file_pkg::*;

module reg_file_xfer_fsm #(
    parameter int PW = DEF_PW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          spill_req,
    input  logic          fill_req,
    input  logic          mem_ack,
    output logic          busy,
    output logic          done,
    output logic          mem_req,
    output logic          mem_we,
    output logic [PW-1:0] mem_addr,
    output logic          fill_we,
    output logic [PW-1:0] fill_idx
);

    localparam logic [PW-1:0] LAST = '1;

    xfer_state_t   state;
    logic [PW-1:0] idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (spill_req) begin
                        state <= SPILL;
                        idx   <= '0;
                    end else if (fill_req) begin
                        state <= FILL;
                        idx   <= '0;
                    end
                end
                SPILL, FILL: begin
                    if (mem_ack) begin
                        // idx wraps to 0 on the last beat
                        idx <= idx + 1'b1;
                        if (idx == LAST) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy     = (state != IDLE);
    assign mem_req  = busy;
    assign mem_we   = (state == SPILL);
    assign mem_addr = idx;
    assign fill_we  = (state == FILL) && mem_ack;
    assign fill_idx = idx;

endmodule

// File: rtl/reg_file_spill.sv
// Register file with two read ports, one write port and a spill/fill engine.
import reg_file_pkg::*;

module reg_file_spill #(
    parameter int DW     = DEF_DW,
    parameter int PW     = DEF_PW,
    parameter int BYPASS = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic          alu_src,
    input  logic [PW-1:0] wr_addr,
    input  logic [DW-1:0] dat_in,
    input  logic [DW-1:0] immed,
    input  logic [PW-1:0] rd_addr_a,
    input  logic [PW-1:0] rd_addr_b,
    output logic [DW-1:0] dat_a_out,
    output logic [DW-1:0] dat_b_out,
    input  logic          spill_req,
    input  logic          fill_req,
    output logic          busy,
    output logic          done,
    output logic          mem_req,
    output logic          mem_we,
    output logic [PW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack
);

    localparam int NREG = 2 ** PW;

    logic [DW-1:0] core [NREG];
    logic          wr_ok;
    logic [PW-1:0] wr_ptr;
    logic [DW-1:0] wr_data;
    logic          fill_we;
    logic [PW-1:0] fill_idx;

    reg_file_xfer_fsm #(
        .PW(PW)
    ) u_fsm (
        .clk      (clk),
        .rst_n    (rst_n),
        .spill_req(spill_req),
        .fill_req (fill_req),
        .mem_ack  (mem_ack),
        .busy     (busy),
        .done     (done),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .fill_we  (fill_we),
        .fill_idx (fill_idx)
    );

    // datapath writes are dropped, not queued, while a transfer runs
    assign wr_ok   = wr_en && !busy;
    assign wr_ptr  = alu_src ? '0 : wr_addr;
    assign wr_data = alu_src ? immed : dat_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                core[i] <= '0;
            end
        end else if (fill_we) begin
            core[fill_idx] <= mem_rdata;
        end else if (wr_ok) begin
            core[wr_ptr] <= wr_data;
        end
    end

    always_comb begin
        dat_a_out = core[rd_addr_a];
        dat_b_out = core[rd_addr_b];
        if (BYPASS != 0 && wr_ok) begin
            if (rd_addr_a == wr_ptr) dat_a_out = wr_data;
            if (rd_addr_b == wr_ptr) dat_b_out = wr_data;
        end
    end

    assign mem_wdata = mem_we ? core[mem_addr] : '0;

endmodule

// File: tb/tb_reg_file_spill.sv
// Bench: a BYPASS=1 and a BYPASS=0 instance on shared stimulus, checked against an array model.
module tb_reg_file_spill;

    localparam int DW   = 8;
    localparam int PW   = 3;
    localparam int NREG = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_en = 1'b0;
    logic          alu_src = 1'b0;
    logic [PW-1:0] wr_addr = '0;
    logic [DW-1:0] dat_in = '0;
    logic [DW-1:0] immed = '0;
    logic [PW-1:0] rd_addr_a = '0;
    logic [PW-1:0] rd_addr_b = '0;
    logic          spill_req = 1'b0;
    logic          fill_req = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_ack = 1'b0;

    logic [DW-1:0] a1, b1, a0, b0;
    logic          busy, done, mem_req, mem_we;
    logic [PW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          n_busy, n_done, n_req, n_we;
    logic [PW-1:0] n_addr;
    logic [DW-1:0] n_wdata;

    int total = 0;
    int bad = 0;
    logic [DW-1:0] model [NREG];

    always #5 clk = ~clk;

    reg_file_spill #(.DW(DW), .PW(PW), .BYPASS(1)) u_byp (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .alu_src(alu_src),
        .wr_addr(wr_addr), .dat_in(dat_in), .immed(immed),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .dat_a_out(a1), .dat_b_out(b1),
        .spill_req(spill_req), .fill_req(fill_req),
        .busy(busy), .done(done), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    reg_file_spill #(.DW(DW), .PW(PW), .BYPASS(0)) u_nb (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .alu_src(alu_src),
        .wr_addr(wr_addr), .dat_in(dat_in), .immed(immed),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .dat_a_out(a0), .dat_b_out(b0),
        .spill_req(spill_req), .fill_req(fill_req),
        .busy(n_busy), .done(n_done), .mem_req(n_req), .mem_we(n_we),
        .mem_addr(n_addr), .mem_wdata(n_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    typedef struct {
        logic       we;
        logic       alu;
        logic [2:0] wa;
        logic [7:0] din;
        logic [7:0] imm;
        logic [2:0] ra;
        logic [2:0] rb;
        logic [7:0] ea;
        logic [7:0] eb;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        wr_en = 0; spill_req = 0; fill_req = 0; mem_ack = 0;
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        for (int i = 0; i < NREG; i++) model[i] = '0;
    endtask

    task automatic chk_reads(input string tag, input bit idle);
        logic [PW-1:0] eff;
        logic [DW-1:0] wd, ea, eb;
        eff = alu_src ? 3'd0 : wr_addr;
        wd  = alu_src ? immed : dat_in;
        ea  = (idle && wr_en && rd_addr_a == eff) ? wd : model[rd_addr_a];
        eb  = (idle && wr_en && rd_addr_b == eff) ? wd : model[rd_addr_b];
        chk({tag, "_a_byp"}, a1, ea);
        chk({tag, "_b_byp"}, b1, eb);
        chk({tag, "_a_nb"}, a0, model[rd_addr_a]);
        chk({tag, "_b_nb"}, b0, model[rd_addr_b]);
    endtask

    // req_mode: 0 spill, 1 fill, 2 both; ack_mode: 0 always, 1 every 3rd, 2 random
    task automatic do_xfer(input int req_mode, input int ack_mode, input bit poke);
        int beat, cyc;
        bit ack, spill;
        logic [DW-1:0] rd;
        spill = (req_mode != 1);
        spill_req = (req_mode != 1);
        fill_req  = (req_mode != 0);
        tick;
        spill_req = 0;
        fill_req  = 0;
        chk("start_we", mem_we, spill);
        beat = 0;
        cyc  = 0;
        while (beat < NREG && cyc < 200) begin
            case (ack_mode)
                0:       ack = 1;
                1:       ack = (cyc % 3 == 2);
                default: ack = 1'($urandom_range(0, 1));
            endcase
            rd = (ack_mode == 2) ? 8'($urandom) : 8'(8'hF0 + beat);
            mem_ack   = ack;
            mem_rdata = rd;
            if (poke) begin
                wr_en = 1; alu_src = 0; wr_addr = 3; dat_in = 8'h99;
            end
            rd_addr_a = 3'($urandom);
            rd_addr_b = 3'($urandom);
            #1;
            chk("x_busy", busy, 1);
            chk("x_req", mem_req, 1);
            chk("x_we", mem_we, spill);
            chk("x_addr", mem_addr, beat);
            chk("x_wdata", mem_wdata, spill ? model[beat] : 8'h00);
            chk("x_done", done, 0);
            chk_reads("x_rd", 0);
            tick;
            if (ack) begin
                if (!spill) model[beat] = rd;
                beat++;
            end
            cyc++;
        end
        mem_ack = 0;
        wr_en   = 0;
        if (beat < NREG) chk("xfer_timeout", beat, NREG);
        chk("end_done", done, 1);
        chk("end_busy", busy, 0);
        chk("end_req", mem_req, 0);
        chk("end_nb_done", n_done, 1);
        if (ack_mode == 0) chk("cycles_fast", cyc, NREG);
        if (ack_mode == 1) chk("cycles_slow", cyc, 3 * NREG);
        tick;
        chk("done_pulse", done, 0);
    endtask

    initial begin
        tbl[0] = '{1'b1, 1'b0, 3'd5, 8'hA7, 8'h00, 3'd5, 3'd5, 8'hA7, 8'h00};
        tbl[1] = '{1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 3'd5, 3'd5, 8'hA7, 8'hA7};
        tbl[2] = '{1'b1, 1'b1, 3'd6, 8'h11, 8'h3C, 3'd0, 3'd6, 8'h3C, 8'h00};
        tbl[3] = '{1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 3'd0, 3'd6, 8'h3C, 8'h00};
        tbl[4] = '{1'b1, 1'b0, 3'd2, 8'h55, 8'h00, 3'd2, 3'd2, 8'h55, 8'h00};
        tbl[5] = '{1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 3'd2, 3'd5, 8'h55, 8'hA7};

        do_reset;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_req", mem_req, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        for (int i = 0; i < NREG; i++) begin
            rd_addr_a = 3'(i);
            rd_addr_b = 3'(i);
            #1;
            chk("rst_rd_a", a1, 0);
            chk("rst_rd_b", b0, 0);
        end

        for (int i = 0; i < 6; i++) begin
            wr_en = tbl[i].we; alu_src = tbl[i].alu; wr_addr = tbl[i].wa;
            dat_in = tbl[i].din; immed = tbl[i].imm;
            rd_addr_a = tbl[i].ra; rd_addr_b = tbl[i].rb;
            #1;
            chk("tbl_a_byp", a1, tbl[i].ea);
            chk("tbl_b_nb", b0, tbl[i].eb);
            tick;
        end
        wr_en = 0;

        do_reset;
        for (int i = 0; i < NREG; i++) begin
            wr_en = 1; alu_src = 0; wr_addr = 3'(i); dat_in = 8'(8'h10 + i);
            tick;
            model[i] = 8'(8'h10 + i);
        end
        wr_en = 0;

        do_xfer(0, 0, 0);
        do_xfer(1, 1, 1);
        for (int i = 0; i < NREG; i++) begin
            rd_addr_a = 3'(i);
            #1;
            chk("fill_val_byp", a1, 8'hF0 + i);
            chk("fill_val_nb", a0, 8'hF0 + i);
        end
        do_xfer(2, 2, 0);

        for (int n = 0; n < 150; n++) begin
            logic [PW-1:0] eff;
            wr_en = 1'($urandom_range(0, 1));
            alu_src = ($urandom_range(0, 3) == 0);
            wr_addr = 3'($urandom);
            dat_in = 8'($urandom);
            immed = 8'($urandom);
            rd_addr_a = 3'($urandom);
            rd_addr_b = 3'($urandom);
            mem_ack = 1'($urandom_range(0, 1));
            #1;
            chk_reads("rnd", 1);
            chk("rnd_idle_busy", busy, 0);
            eff = alu_src ? 3'd0 : wr_addr;
            tick;
            if (wr_en) model[eff] = alu_src ? immed : dat_in;
        end
        wr_en = 0;
        mem_ack = 0;

        do_xfer(1, 2, 1);
        do_xfer(0, 2, 0);

        fill_req = 1;
        tick;
        fill_req = 0;
        mem_ack = 1;
        mem_rdata = 8'hEE;
        repeat (4) tick;
        mem_ack = 0;
        chk("abort_addr4", mem_addr, 4);
        rst_n = 0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_req", mem_req, 0);
        chk("abort_addr", mem_addr, 0);
        chk("abort_wdata", mem_wdata, 0);
        for (int i = 0; i < NREG; i++) begin
            rd_addr_a = 3'(i);
            #1;
            chk("abort_rd", a1, 0);
        end
        @(posedge clk);
        #1;
        rst_n = 1;
        for (int i = 0; i < 4; i++) begin
            tick;
            chk("abort_no_done", done, 0);
            chk("abort_no_busy", busy, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
